// File: rtl/dt_share_ctrl.sv
// Round-robin owner arbiter for the shared 4-digit display driver.
// Grants one requester at a time with a guaranteed minimum hold.
module dt_share_ctrl #(
  parameter int unsigned HOLD_CYCLES = 48000000,
  parameter logic [15:0] IDLE_VAL    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic        owner_valid,
  output logic        switch_pulse,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [31:0] HOLD_LD = 32'(HOLD_CYCLES - 1);

  state_t      state, state_n;
  logic [1:0]  own, own_n;
  logic [1:0]  ptr, ptr_n;
  logic [31:0] hold, hold_n;
  logic [2:0]  grant_n;
  logic        pulse_n;
  logic [15:0] disp, disp_n;

  logic [2:0]  cand, pick;
  logic [1:0]  pick_idx;
  logic        pick_ok, take, expired;
  logic [15:0] own_data, pick_data;

  function automatic logic [2:0] rr_pick(
    input logic [2:0] r,
    input logic [1:0] p
  );
    logic [2:0] g;
    case (p)
      2'd1:    g = r[1] ? 3'b010 : r[2] ? 3'b100 :
                   r[0] ? 3'b001 : 3'b000;
      2'd2:    g = r[2] ? 3'b100 : r[0] ? 3'b001 :
                   r[1] ? 3'b010 : 3'b000;
      default: g = r[0] ? 3'b001 : r[1] ? 3'b010 :
                   r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] idx_of(input logic [2:0] g);
    logic [1:0] i;
    unique case (1'b1)
      g[1]:    i = 2'd1;
      g[2]:    i = 2'd2;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  function automatic logic [15:0] sel_data(input logic [1:0] i,
    input logic [15:0] d0, input logic [15:0] d1,
    input logic [15:0] d2);
    logic [15:0] d;
    case (i)
      2'd0:    d = d0;
      2'd1:    d = d1;
      default: d = d2;
    endcase
    return d;
  endfunction

  // The current owner never competes against itself at expiry.
  always_comb begin
    cand    = (state == OWN) ? (req & ~grant) : req;
    pick    = rr_pick(cand, ptr);
    pick_ok = |pick;
    pick_idx = idx_of(pick);
    expired = (hold == 32'd0);
    take    = pick_ok && (state == IDLE || expired);
    state_n = state;
    unique case (state)
      IDLE: if (pick_ok) state_n = OWN;
      OWN:  if (expired && !pick_ok && !req[own])
              state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    own_data  = sel_data(own, data0, data1, data2);
    pick_data = sel_data(pick_idx, data0, data1, data2);
    grant_n = grant;
    own_n   = own;
    ptr_n   = ptr;
    hold_n  = hold;
    pulse_n = 1'b0;
    disp_n  = disp;
    if (take) begin
      grant_n = pick;
      own_n   = pick_idx;
      ptr_n   = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
      hold_n  = HOLD_LD;
      pulse_n = 1'b1;
      disp_n  = pick_data;
    end else if (state == OWN) begin
      if (!expired) hold_n = hold - 32'd1;
      if (state_n == IDLE) begin
        grant_n = 3'b000;
        disp_n  = IDLE_VAL;
      end else if (req[own]) begin
        disp_n = own_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      own          <= 2'd0;
      ptr          <= 2'd0;
      hold         <= 32'd0;
      grant        <= 3'b000;
      owner_valid  <= 1'b0;
      switch_pulse <= 1'b0;
      disp         <= IDLE_VAL;
    end else begin
      state        <= state_n;
      own          <= own_n;
      ptr          <= ptr_n;
      hold         <= hold_n;
      grant        <= grant_n;
      owner_valid  <= |grant_n;
      switch_pulse <= pulse_n;
      disp         <= disp_n;
    end
  end

  assign num1 = disp[15:12];
  assign num2 = disp[11:8];
  assign num3 = disp[7:4];
  assign num4 = disp[3:0];

endmodule

// File: tb/tb_dt_share_ctrl.sv
// Directed bench for dt_share_ctrl, HOLD_CYCLES=4, IDLE_VAL=E000.
// Compares grant/owner_valid/switch_pulse/num after each edge.
module tb_dt_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  grant;
  logic        owner_valid, switch_pulse;
  logic [3:0]  num1, num2, num3, num4;

  int total = 0;
  int bad   = 0;

  dt_share_ctrl #(
    .HOLD_CYCLES(4),
    .IDLE_VAL(16'hE000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data0(data0),
    .data1(data1),
    .data2(data2),
    .grant(grant),
    .owner_valid(owner_valid),
    .switch_pulse(switch_pulse),
    .num1(num1),
    .num2(num2),
    .num3(num3),
    .num4(num4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector is {grant, owner_valid, switch_pulse, num1..num4}.
  task automatic chk(input string tag, input logic [2:0] g,
    input logic sp, input logic [15:0] n);
    logic [20:0] obs, exp;
    obs = {grant, owner_valid, switch_pulse, num1, num2, num3, num4};
    exp = {g, |g, sp, n};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0]  eg;
    logic [15:0] ed;
    rst_n = 1'b0;
    req   = 3'b111;
    data0 = 16'h0123;
    data1 = 16'h1234;
    data2 = 16'h9876;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 3'b000, 1'b0, 16'hE000);
    end
    rst_n = 1'b1;

    // All three requesting: 4 cycles each, 0 -> 1 -> 2 -> 0 -> 1.
    for (int c = 1; c <= 20; c++) begin
      tick();
      case (((c - 1) / 4) % 3)
        0: begin eg = 3'b001; ed = 16'h0123; end
        1: begin eg = 3'b010; ed = 16'h1234; end
        default: begin eg = 3'b100; ed = 16'h9876; end
      endcase
      chk("rr_all", eg, ((c - 1) % 4) == 0, ed);
    end

    rst_n = 1'b0;
    req   = 3'b000;
    tick();
    chk("reset_mid", 3'b000, 1'b0, 16'hE000);
    rst_n = 1'b1;
    tick();
    chk("idle_noreq", 3'b000, 1'b0, 16'hE000);

    // Single requester 1, data change seen one cycle later.
    req = 3'b010;
    tick();
    chk("r1_grant", 3'b010, 1'b1, 16'h1234);
    data0 = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r1_hold", 3'b010, 1'b0, 16'h1234);
    end
    data1 = 16'hABCD;
    tick();
    chk("r1_data", 3'b010, 1'b0, 16'hABCD);
    req = 3'b000;
    tick();
    chk("r1_release", 3'b000, 1'b0, 16'hE000);

    // One-cycle pulse on req[0]: hold 4 cycles with frozen digits.
    req   = 3'b001;
    data0 = 16'h5A5A;
    tick();
    chk("p0_grant", 3'b001, 1'b1, 16'h5A5A);
    req   = 3'b000;
    data0 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p0_freeze", 3'b001, 1'b0, 16'h5A5A);
    end
    tick();
    chk("p0_idle", 3'b000, 1'b0, 16'hE000);

    // Owner 0, requester 2 arrives mid-hold and waits for expiry.
    req   = 3'b001;
    data0 = 16'h0123;
    tick();
    chk("mh_grant0", 3'b001, 1'b1, 16'h0123);
    tick();
    chk("mh_c2", 3'b001, 1'b0, 16'h0123);
    req = 3'b101;
    tick();
    chk("mh_c3", 3'b001, 1'b0, 16'h0123);
    tick();
    chk("mh_c4", 3'b001, 1'b0, 16'h0123);
    tick();
    chk("mh_switch2", 3'b100, 1'b1, 16'h9876);
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mh_hold2", 3'b100, 1'b0, 16'h9876);
    end
    tick();
    chk("mh_tie0", 3'b001, 1'b1, 16'h0123);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mh_hold0", 3'b001, 1'b0, 16'h0123);
    end
    tick();
    chk("mh_next1", 3'b010, 1'b1, 16'hABCD);
    tick();
    chk("mh_hold1", 3'b010, 1'b0, 16'hABCD);

    // Reset during owner 1's hold clears rr_ptr too.
    rst_n = 1'b0;
    tick();
    chk("rst_in_hold", 3'b000, 1'b0, 16'hE000);
    rst_n = 1'b1;
    req   = 3'b110;
    tick();
    chk("rst_ptr0", 3'b010, 1'b1, 16'hABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dt_share_ctrl.md
Name: dt_share_ctrl

Overview:
Round-robin arbiter and sequencer that shares the 4-digit 7-segment display driver (dt_module, 48 MHz domain) between three requesters. Each requester presents a 16-bit hex value. The controller grants one owner at a time and guarantees it a minimum display hold time. It drives num1..num4 of dt_module directly from the owner's value, and drives an idle pattern when nobody requests.

Parameters:
HOLD_CYCLES, 48000000, minimum cycles an owner keeps the display once granted (1 s at 48 MHz); legal range 1..2^32-1.
IDLE_VAL, 16'h0000, value shown when no owner (num1 = IDLE_VAL[15:12] ... num4 = IDLE_VAL[3:0]).

Ports:
clk  in  1  system clock, 48 MHz, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req  in  3  request per requester; level, held while the requester wants the display
data0  in  16  value of requester 0; [15:12] is the leftmost digit
data1  in  16  value of requester 1
data2  in  16  value of requester 2
grant  out  3  one-hot current owner, registered; all zero when idle
owner_valid  out  1  high while an owner holds the display
switch_pulse  out  1  one-cycle pulse on each cycle in which grant changes to a new non-zero owner
num1  out  4  leftmost digit to dt_module
num2  out  4  second digit
num3  out  4  third digit
num4  out  4  rightmost digit

Behaviour:
- Reset (rst_n low at an edge):
  - grant=0, owner_valid=0, switch_pulse=0.
  - num1..num4 = IDLE_VAL nibbles.
  - State=IDLE, rr_ptr=0, hold_cnt=0.
  - Reset applies mid-operation in the same way; no state survives it.
- States: IDLE and OWN. All outputs are registered.
- Round-robin pick:
  - Scan requesters starting at rr_ptr and wrapping 0→1→2→0.
  - The first requester with req high wins.
  - On every grant, rr_ptr becomes (winner+1) mod 3.
- IDLE:
  - If any req is high at edge N, then at edge N+1: grant=onehot(winner), owner_valid=1, switch_pulse=1, hold_cnt=HOLD_CYCLES-1, state=OWN.
  - The num outputs at N+1 take data_winner as sampled at edge N.
  - If no req, outputs stay at idle values.
- OWN, data path:
  - While req[owner] is high, num1..num4 register data_owner each cycle. Latency is 1 cycle from a data change to the num outputs.
  - If req[owner] drops before hold expiry, the num outputs freeze at the last value captured while req was high. The owner is retained until hold_cnt reaches 0.
- OWN, hold counter: hold_cnt decrements by 1 each cycle and saturates at 0.
- OWN, decision when hold_cnt==0, made at each edge:
  - Another requester (not the owner) has req high: switch to the round-robin winner among the non-owner requesters. The current owner is excluded from this scan even if its req is still high.
    - The new grant takes effect at the next edge with no idle gap.
    - switch_pulse=1 and hold_cnt reloads to HOLD_CYCLES-1.
    - The num outputs at that edge take the new owner's data.
  - Else if req[owner] is high: keep the owner, hold_cnt stays 0, and re-evaluate every cycle.
  - Else (no requests): go to IDLE at the next edge. grant=0, owner_valid=0, num outputs = IDLE_VAL nibbles.
- HOLD_CYCLES=1: hold_cnt loads 0, so ownership is re-arbitrated every cycle. With all three requesting, grant cycles 0→1→2→0.
- Simultaneous events: a requester raising req in the same cycle the owner expires competes under normal round-robin. Requests that arrive before expiry are only evaluated at expiry.
- Data inputs of non-owners are ignored.
- grant is always one-hot or zero, and owner_valid equals |grant.
- switch_pulse is never high two cycles in a row unless HOLD_CYCLES=1.

Test Plan:
Use HOLD_CYCLES=4 and IDLE_VAL=16'hE000 unless stated otherwise.
1. Reset held 3 cycles with req=3'b111 → grant=0, owner_valid=0, num1..num4 = E,0,0,0 throughout. First edge after release → grant=3'b001, switch_pulse=1, num = data0.
2. Only req[1] high with data1=16'h1234, changing to 16'hABCD at cycle 10 → grant=3'b010 from the cycle after req. num=1,2,3,4, then A,B,C,D exactly 1 cycle after the change. Ownership is held indefinitely with switch_pulse low after the first pulse.
3. req=3'b111 held for 20 cycles → grant sequence 001,010,100,001,… with each owner for exactly 4 cycles. switch_pulse fires every 4th cycle.
4. req[0] pulses for 1 cycle with data0=16'h5A5A, then drops; no other requests → grant=001 for 4 cycles, num frozen at 5,A,5,A. Then at the next edge → IDLE with grant=0, num=E,0,0,0.
5. Owner 0 granted; req[2] rises at cycle 2 of the hold → grant stays 001 until hold_cnt=0, then switches to 100 with no gap. rr_ptr then favours requester 0 over 1 at the next tie.
6. Assert rst_n low mid-hold while grant=010 → at the next edge all outputs return to reset values. After release with req=3'b110 → grant=010, because rr_ptr was reset to 0 and requester 0 is not requesting.
